// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC/nPC/MAR/IR steering with MFC wait and timeout fault
module fetch_sequencer #(
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [5:0]  OP_ADD      = 6'b000000,
  parameter logic [5:0]  OP_AND      = 6'b000001,
  parameter logic [5:0]  RAM_RD_WORD = 6'b000000
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       fetch_req,
  input  logic       trap_pending,
  input  logic       MFC,
  output logic       MAR_Enable,
  output logic       IR_Enable,
  output logic       PC_enable,
  output logic       NPC_enable,
  output logic       RAM_enable,
  output logic [5:0] RAM_OpCode,
  output logic [1:0] PC_In_Mux_select,
  output logic [1:0] ALUA_Mux_select,
  output logic [3:0] ALUB_Mux_select,
  output logic [5:0] ALU_op,
  output logic       busy,
  output logic       fetch_done,
  output logic       mem_timeout
);

  typedef enum logic [2:0] {
    IDLE, TRAP_PC, TRAP_NPC, LOAD_MAR, MEM_READ, UPDATE, FAULT
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Outputs decode from the registered state only, so Clr zeroes them without waiting for an edge.
  always_comb begin
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    MAR_Enable       = 1'b0;
    IR_Enable        = 1'b0;
    PC_enable        = 1'b0;
    NPC_enable       = 1'b0;
    RAM_enable       = 1'b0;
    RAM_OpCode       = 6'b000000;
    PC_In_Mux_select = 2'b00;
    ALUA_Mux_select  = 2'b00;
    ALUB_Mux_select  = 4'b0000;
    ALU_op           = 6'b000000;
    busy             = 1'b1;
    fetch_done       = 1'b0;
    mem_timeout      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (fetch_req) state_nxt = trap_pending ? TRAP_PC : LOAD_MAR;
      end
      TRAP_PC: begin
        PC_In_Mux_select = 2'b10;
        PC_enable        = 1'b1;
        state_nxt        = TRAP_NPC;
      end
      TRAP_NPC: begin
        ALUA_Mux_select = 2'b01;
        ALUB_Mux_select = 4'b0110;
        ALU_op          = OP_ADD;
        NPC_enable      = 1'b1;
        state_nxt       = LOAD_MAR;
      end
      LOAD_MAR: begin
        ALUA_Mux_select = 2'b01;
        ALUB_Mux_select = 4'b0011;
        ALU_op          = OP_AND;
        MAR_Enable      = 1'b1;
        wait_cnt_nxt    = '0;
        state_nxt       = MEM_READ;
      end
      MEM_READ: begin
        RAM_enable = 1'b1;
        RAM_OpCode = RAM_RD_WORD;
        IR_Enable  = MFC;
        // MFC takes priority over the timeout on the final permitted cycle.
        if (MFC) state_nxt = UPDATE;
        else if (wait_cnt == CNT_LAST) state_nxt = FAULT;
        else wait_cnt_nxt = wait_cnt + 8'd1;
      end
      UPDATE: begin
        PC_In_Mux_select = 2'b00;
        PC_enable        = 1'b1;
        ALUA_Mux_select  = 2'b10;
        ALUB_Mux_select  = 4'b0110;
        ALU_op           = OP_ADD;
        NPC_enable       = 1'b1;
        fetch_done       = 1'b1;
        state_nxt        = IDLE;
      end
      FAULT: begin
        mem_timeout = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer with a datapath and latency model
module tb_fetch_sequencer;
  localparam int          TO       = 16;
  localparam logic [5:0]  OP_ADD   = 6'b000000;
  localparam logic [5:0]  OP_AND   = 6'b000001;
  localparam logic [5:0]  RD_WORD  = 6'b000000;

  logic       Clk, Clr, fetch_req, trap_pending, MFC;
  logic       MAR_Enable, IR_Enable, PC_enable, NPC_enable, RAM_enable;
  logic [5:0] RAM_OpCode, ALU_op;
  logic [1:0] PC_In_Mux_select, ALUA_Mux_select;
  logic [3:0] ALUB_Mux_select;
  logic       busy, fetch_done, mem_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.TIMEOUT(TO), .OP_ADD(OP_ADD), .OP_AND(OP_AND), .RAM_RD_WORD(RD_WORD)) dut (
    .Clk(Clk), .Clr(Clr), .fetch_req(fetch_req), .trap_pending(trap_pending), .MFC(MFC),
    .MAR_Enable(MAR_Enable), .IR_Enable(IR_Enable), .PC_enable(PC_enable),
    .NPC_enable(NPC_enable), .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode),
    .PC_In_Mux_select(PC_In_Mux_select), .ALUA_Mux_select(ALUA_Mux_select),
    .ALUB_Mux_select(ALUB_Mux_select), .ALU_op(ALU_op), .busy(busy),
    .fetch_done(fetch_done), .mem_timeout(mem_timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Datapath the sequencer steers: PC, nPC, MAR, TBR and a two-function ALU.
  logic [31:0] pc, npc, mar, tbr, alu_a, alu_b, alu_y, pc_in;
  always_comb begin
    alu_a = (ALUA_Mux_select == 2'b01) ? pc : (ALUA_Mux_select == 2'b10) ? npc : 32'd0;
    alu_b = (ALUB_Mux_select == 4'b0110) ? 32'd4 : (ALUB_Mux_select == 4'b0011) ? pc : 32'd0;
    alu_y = (ALU_op == OP_AND) ? (alu_a & alu_b) : (alu_a + alu_b);
    pc_in = (PC_In_Mux_select == 2'b10) ? tbr : npc;
  end
  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      pc <= 32'd0; npc <= 32'd4; mar <= 32'd0;
    end else begin
      if (PC_enable)  pc  <= pc_in;
      if (NPC_enable) npc <= alu_y;
      if (MAR_Enable) mar <= alu_y;
    end
  end

  wire [27:0] all_outs = {MAR_Enable, IR_Enable, PC_enable, NPC_enable, RAM_enable, RAM_OpCode,
                          PC_In_Mux_select, ALUA_Mux_select, ALUB_Mux_select, ALU_op,
                          busy, fetch_done, mem_timeout};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Clr = 1'b1; fetch_req = 1'b0; trap_pending = 1'b0; MFC = 1'b0;
    #1;
    check("rst_outs", 32'(all_outs), 32'd0);
    tick();
    tick();
    Clr = 1'b0;
  endtask

  // One fetch from IDLE; n is the MEM_READ cycle on which MFC rises (n > TO never completes).
  task automatic do_fetch(input bit trap, input int n);
    logic [31:0] exp_pc, exp_npc;
    int off, mar_c, ram_c, ir_c, done_c, flt_c;
    exp_pc  = trap ? tbr : pc;
    exp_npc = trap ? tbr + 32'd4 : npc;
    off = trap ? 2 : 0;
    mar_c = 0; ram_c = 0; ir_c = 0; done_c = 0; flt_c = 0;
    fetch_req = 1'b1; trap_pending = trap; MFC = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      fetch_req = 1'b0; trap_pending = 1'b0;
      MFC = (c == off + 1 + n);
      #1;
      if (MAR_Enable) mar_c++;
      if (IR_Enable) ir_c++;
      if (RAM_enable) begin
        ram_c++;
        check("ram_opcode", 32'(RAM_OpCode), 32'(RD_WORD));
      end
      if (fetch_done) begin
        done_c = c;
        check("pc_at_done", pc, exp_pc);
        check("npc_at_done", npc, exp_npc);
        check("mar_at_done", mar, exp_pc);
        break;
      end
      if (mem_timeout) begin
        flt_c = c;
        break;
      end
    end
    MFC = 1'b0;
    if (n <= TO) begin
      check("done_latency", done_c, off + n + 2);
      check("mar_cycles", mar_c, 1);
      check("ram_cycles", ram_c, n);
      check("ir_cycles", ir_c, 1);
      check("no_timeout", 32'(mem_timeout), 32'd0);
      tick();
      check("pc_after", pc, exp_npc);
      check("npc_after", npc, exp_npc + 32'd4);
      check("idle_busy", 32'(busy), 32'd0);
      check("done_pulse", 32'(fetch_done), 32'd0);
    end else begin
      check("fault_cycle", flt_c, off + TO + 2);
      check("ram_cycles_to", ram_c, TO);
      check("ir_cycles_to", ir_c, 0);
      check("fault_busy", 32'(busy), 32'd1);
      check("fault_ram", 32'(RAM_enable), 32'd0);
      fetch_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        check("fault_sticky", 32'({mem_timeout, busy}), 32'h3);
        check("fault_strobes", 32'({MAR_Enable, PC_enable, NPC_enable, RAM_enable, IR_Enable}), 32'd0);
      end
      apply_reset();
      check("fault_cleared", 32'(mem_timeout), 32'd0);
    end
  endtask

  initial begin
    Clr = 1'b1; fetch_req = 1'b0; trap_pending = 1'b0; MFC = 1'b0; tbr = 32'h100;
    apply_reset();

    do_fetch(1'b0, 3);
    tbr = 32'h100;
    do_fetch(1'b1, 3);
    do_fetch(1'b0, TO);
    do_fetch(1'b0, TO + 1);

    // Asynchronous clear while waiting on memory.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    check("mid_read_ram", 32'(RAM_enable), 32'd1);
    #2 Clr = 1'b1;
    #1 check("clr_async_outs", 32'(all_outs), 32'd0);
    tick();
    Clr = 1'b0;
    do_fetch(1'b0, 2);

    // Back-to-back fetches with fetch_req held and memory responding immediately.
    begin
      logic [31:0] pc0, npc0;
      int dones;
      pc0 = pc; npc0 = npc; dones = 0;
      fetch_req = 1'b1; MFC = 1'b1;
      for (int c = 1; c <= 12; c++) begin
        tick();
        #1;
        if (fetch_done) begin
          check("b2b_spacing", c, 3 + 4 * dones);
          check("b2b_pc", pc, (dones == 0) ? pc0 : npc0 + 32'(4 * (dones - 1)));
          dones++;
          if (dones == 3) fetch_req = 1'b0;
        end
      end
      MFC = 1'b0; fetch_req = 1'b0;
      check("b2b_count", dones, 3);
      check("b2b_pc_final", pc, npc0 + 32'd8);
      check("b2b_idle", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      tbr = $urandom & 32'hFFFF_FFFC;
      do_fetch(1'($urandom_range(0, 1)), $urandom_range(1, TO + 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning max MEM_READ cycles without MFC before fault; legal range 1..255.
REQ-002 Parameter OP_ADD, default 6'b000000, meaning ALU add opcode.
REQ-003 Parameter OP_AND, default 6'b000001, meaning ALU AND opcode (used as pass-through: PC & PC).
REQ-004 Parameter RAM_RD_WORD, default 6'b000000, meaning RAM opcode for 32-bit word read.
REQ-005 Clk  input  1  sole clock; all state changes on rising edge.
REQ-006 Clr  input  1  reset, asynchronous, active-high.
REQ-007 fetch_req  input  1  control unit requests next instruction fetch.
REQ-008 trap_pending  input  1  redirect fetch to trap vector (PC <- TBR).
REQ-009 MFC  input  1  memory function complete from RAM.
REQ-010 MAR_Enable, IR_Enable, PC_enable, NPC_enable, RAM_enable  output  1 each  datapath load/access strobes.
REQ-011 RAM_OpCode  output  6  RAM operation code.
REQ-012 PC_In_Mux_select  output 2; ALUA_Mux_select  output 2; ALUB_Mux_select  output 4; ALU_op  output 6  datapath steering.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 fetch_done  output  1  one-cycle pulse: IR valid, PC/nPC advanced.
REQ-015 mem_timeout  output  1  sticky fetch fault flag.

Function
REQ-016 States: IDLE, TRAP_PC, TRAP_NPC, LOAD_MAR, MEM_READ, UPDATE, FAULT; outputs are Moore except IR_Enable and exit of MEM_READ (depend on MFC).
REQ-017 Default in every state: all strobes 0, all selects 0, ALU_op 0, fetch_done 0; each state overrides only listed signals.
REQ-018 IDLE: fetch_req=1 and trap_pending=1 -> TRAP_PC; fetch_req=1 and trap_pending=0 -> LOAD_MAR; else stay.
REQ-019 TRAP_PC (1 cycle): PC_In_Mux_select=2'b10, PC_enable=1 -> TRAP_NPC.
REQ-020 TRAP_NPC (1 cycle): ALUA=2'b01 (PC), ALUB=4'b0110 (const 4), ALU_op=OP_ADD, NPC_enable=1 -> LOAD_MAR.
REQ-021 LOAD_MAR (1 cycle): ALUA=2'b01, ALUB=4'b0011 (PC), ALU_op=OP_AND, MAR_Enable=1 -> MEM_READ; wait counter cleared to 0.
REQ-022 MEM_READ: RAM_enable=1, RAM_OpCode=RAM_RD_WORD; IR_Enable=MFC; MFC=1 -> UPDATE; else counter+1, and counter reaching TIMEOUT-1 with MFC=0 -> FAULT.
REQ-023 MFC=1 in the same cycle the counter hits its limit: MFC wins, go to UPDATE, no fault.
REQ-024 UPDATE (1 cycle): PC_In_Mux_select=2'b00, PC_enable=1, ALUA=2'b10 (nPC), ALUB=4'b0110, ALU_op=OP_ADD, NPC_enable=1, fetch_done=1 -> IDLE; PC captures old nPC, nPC captures old nPC+4 on the same edge.
REQ-025 FAULT: mem_timeout=1, busy=1, all strobes 0; held until Clr; fetch_req ignored.
REQ-026 fetch_req/trap_pending are sampled only in IDLE; assertion in any other state is ignored (not queued).
REQ-027 Latency, normal path: fetch_req edge -> LOAD_MAR 1 cycle, MEM_READ N cycles (N>=1, MFC on cycle N), UPDATE; fetch_done N+2 cycles after IDLE exit edge; trap path adds 2 cycles.
REQ-028 Wait counter 8 bits, never wraps (bounded by TIMEOUT<=255).
REQ-029 Back-to-back: fetch_req held high re-enters LOAD_MAR the cycle after UPDATE returns to IDLE.

Reset
REQ-030 Clr=1 forces IDLE, counter=0, mem_timeout=0 and all outputs 0 asynchronously, including mid-MEM_READ; no RAM_enable or register strobe may glitch high during reset.
REQ-031 After Clr deasserts, first fetch_req is accepted on the next rising edge.

Verification
REQ-032 Reset, fetch_req=1, trap_pending=0, MFC high on 3rd MEM_READ cycle -> MAR_Enable 1 cycle, RAM_enable 3 cycles, IR_Enable 1 cycle, fetch_done 5 cycles after request edge, PC=old nPC, nPC=old nPC+4.
REQ-033 fetch_req with trap_pending=1, TBR=0x00000100 -> PC=0x100, nPC=0x104, MAR=0x100, fetch_done 2 cycles later than REQ-032 case.
REQ-034 TIMEOUT=16, MFC never asserted -> 16 MEM_READ cycles, then mem_timeout=1, busy=1, RAM_enable=0; persists until Clr.
REQ-035 MFC rises exactly on 16th MEM_READ cycle (TIMEOUT=16) -> UPDATE, mem_timeout stays 0.
REQ-036 Clr pulsed during MEM_READ -> all outputs 0 immediately (before next edge), state IDLE; subsequent fetch completes normally.
REQ-037 fetch_req held high for 3 fetches, MFC immediate -> three fetch_done pulses spaced 4 cycles apart, PC advancing by 4 each.
